// File: rtl/mat_buf_dp.sv
// mat_buf_dp: dual-port lane-masked matrix buffer with output-region clear.
// Define BRAM_OUT_REG_EN for an extra output register stage (2-cycle reads).
module mat_buf_dp #(
  parameter int    LANE_WIDTH = 32,
  parameter int    LANES      = 4,
  parameter int    DEPTH      = 16,
  parameter int    ADDR_WIDTH = $clog2(DEPTH),
  parameter int    CLR_BASE   = 11,
  parameter int    CLR_LEN    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_en,
  input  logic [LANES-1:0]              a_we,
  input  logic [ADDR_WIDTH-1:0]         a_addr,
  input  logic [LANES*LANE_WIDTH-1:0]   a_din,
  output logic                          a_ready,
  output logic [LANES*LANE_WIDTH-1:0]   a_dout,
  output logic                          a_valid,
  input  logic                          b_en,
  input  logic [ADDR_WIDTH-1:0]         b_addr,
  output logic [LANES*LANE_WIDTH-1:0]   b_dout,
  output logic                          b_valid,
  input  logic                          clr_start,
  output logic                          busy,
  output logic                          clr_done,
  output logic                          err
);

  localparam int LW  = LANES * LANE_WIDTH;
  localparam int CW  = $clog2(CLR_LEN + 1);
  localparam int AW1 = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         cnt;
  logic                  clr_we;
  logic                  clr_last;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  a_acc;
  logic                  a_oor;
  logic                  b_oor;
  logic                  a_wr;
  logic [LW-1:0]         a_q;
  logic [LW-1:0]         b_q;
  logic                  a_vq;
  logic                  b_vq;

  logic [LW-1:0] mem [DEPTH];

  assign clr_last = (cnt == CW'(CLR_LEN - 1));
  assign clr_addr = ADDR_WIDTH'(CLR_BASE) + ADDR_WIDTH'(cnt);
  assign a_acc    = a_en && a_ready;
  assign a_oor    = {1'b0, a_addr} >= AW1'(DEPTH);
  assign b_oor    = {1'b0, b_addr} >= AW1'(DEPTH);
  assign a_wr     = a_acc && !a_oor && (|a_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) cnt <= cnt + CW'(1);
      else                cnt <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (clr_start) state_nx = CLEAR;
      CLEAR: if (clr_last)  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == CLEAR);
    clr_we  = busy;
    a_ready = !busy;
  end

  // err: an accepted clr_start clears it, an out-of-range access wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      clr_done <= clr_we && clr_last;
      if (clr_start && !busy)               err <= 1'b0;
      if ((a_acc && a_oor) || (b_en && b_oor)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_we[i])
          mem[a_addr][i*LANE_WIDTH +: LANE_WIDTH]
            <= a_din[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      a_vq <= 1'b0;
      b_vq <= 1'b0;
    end else begin
      a_vq <= a_acc;
      b_vq <= b_en;
      if (a_acc) a_q <= a_oor ? '0 : mem[a_addr];
      if (b_en)  b_q <= b_oor ? '0 : mem[b_addr];
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [LW-1:0] a_q2;
  logic [LW-1:0] b_q2;
  logic          a_vq2;
  logic          b_vq2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q2  <= '0;
      b_q2  <= '0;
      a_vq2 <= 1'b0;
      b_vq2 <= 1'b0;
    end else begin
      a_vq2 <= a_vq;
      b_vq2 <= b_vq;
      if (a_vq) a_q2 <= a_q;
      if (b_vq) b_q2 <= b_q;
    end
  end

  assign a_dout  = a_q2;
  assign a_valid = a_vq2;
  assign b_dout  = b_q2;
  assign b_valid = b_vq2;
`else
  assign a_dout  = a_q;
  assign a_valid = a_vq;
  assign b_dout  = b_q;
  assign b_valid = b_vq;
`endif

endmodule

// File: tb/tb_mat_buf_dp.sv
// tb_mat_buf_dp: table, directed and random checks of mat_buf_dp
// against a cycle-level reference model of the buffer contents.
module tb_mat_buf_dp;

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int CB = 11;
  localparam int CL = 4;

  typedef logic [127:0] line_t;

  typedef struct {
    logic       ae;
    logic [3:0] we;
    logic [3:0] aa;
    line_t      ad;
    logic       be;
    logic [3:0] ba;
    logic       ca;
    line_t      ea;
    logic       cb;
    line_t      eb;
  } vec_t;

  typedef struct {
    logic  av;
    line_t ad;
    logic  bv;
    line_t bd;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_en = 0, b_en = 0, clr_start = 0;
  logic [3:0] a_we = 0, a_addr = 0, b_addr = 0;
  line_t      a_din = '0;
  logic       a_ready, a_valid, b_valid, busy, clr_done, err;
  line_t      a_dout, b_dout;

  logic       x_a_en = 0, x_b_en = 0, x_clr_start = 0;
  logic [3:0] x_a_we = 0, x_a_addr = 0, x_b_addr = 0;
  line_t      x_a_din = '0;
  logic       x_a_ready, x_a_valid, x_b_valid, x_busy, x_clr_done, x_err;
  line_t      x_a_dout, x_b_dout;

  mat_buf_dp u0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_ready(a_ready), .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done), .err(err)
  );

  mat_buf_dp #(.DEPTH(12), .CLR_BASE(6), .CLR_LEN(4)) u1 (
    .clk(clk), .rst(rst),
    .a_en(x_a_en), .a_we(x_a_we), .a_addr(x_a_addr), .a_din(x_a_din),
    .a_ready(x_a_ready), .a_dout(x_a_dout), .a_valid(x_a_valid),
    .b_en(x_b_en), .b_addr(x_b_addr), .b_dout(x_b_dout),
    .b_valid(x_b_valid), .clr_start(x_clr_start), .busy(x_busy),
    .clr_done(x_clr_done), .err(x_err)
  );

  int    n_chk = 0;
  int    n_err = 0;
  line_t mref [16];
  int    clr_left;
  logic  err_m, done_m;
  line_t a_last, b_last;
  ent_t  pq [$];
  vec_t  tbl [7];

  task automatic chk(input string name, input line_t got, input line_t want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  function automatic line_t pat(int i);
    return {4{32'h5A00_0000 + 32'(i)}};
  endfunction

  task automatic model_reset();
    clr_left = 0;
    err_m    = 1'b0;
    done_m   = 1'b0;
    a_last   = '0;
    b_last   = '0;
    pq.delete();
    for (int i = 0; i < LAT; i++) pq.push_back('{1'b0, '0, 1'b0, '0});
  endtask

  // One clock of u0: check outputs, drive inputs, advance the model.
  task automatic cycle(input logic ae, input logic [3:0] we,
                       input logic [3:0] aa, input line_t ad,
                       input logic be, input logic [3:0] ba,
                       input logic cs);
    ent_t h, e;
    logic bz;
    h = pq.pop_front();
    chk1("a_valid", a_valid, h.av);
    chk("a_dout", a_dout, h.ad);
    chk1("b_valid", b_valid, h.bv);
    chk("b_dout", b_dout, h.bd);
    chk1("busy", busy, clr_left > 0);
    chk1("a_ready", a_ready, clr_left == 0);
    chk1("clr_done", clr_done, done_m);
    chk1("err", err, err_m);
    a_en = ae; a_we = we; a_addr = aa; a_din = ad;
    b_en = be; b_addr = ba; clr_start = cs;
    bz = clr_left > 0;
    e.av = ae && !bz;
    e.ad = e.av ? mref[aa] : a_last;
    a_last = e.ad;
    e.bv = be;
    e.bd = be ? mref[ba] : b_last;
    b_last = e.bd;
    done_m = 1'b0;
    if (bz) begin
      mref[CB + CL - clr_left] = '0;
      clr_left--;
      done_m = (clr_left == 0);
    end
    if (e.av)
      for (int i = 0; i < 4; i++)
        if (we[i]) mref[aa][i*32 +: 32] = ad[i*32 +: 32];
    if (cs && !bz) begin
      clr_left = CL;
      err_m    = 1'b0;
    end
    pq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic rd_check(input int addr, input line_t want, input string name);
    cycle(1'b1, 4'h0, 4'(addr), '0, 1'b0, 4'h0, 1'b0);
    repeat (LAT - 1) idle();
    chk1({name, "_v"}, a_valid, 1'b1);
    chk(name, a_dout, want);
  endtask

  task automatic do_reset();
    a_en = 0; a_we = 0; a_addr = 0; a_din = '0;
    b_en = 0; b_addr = 0; clr_start = 0;
    x_a_en = 0; x_a_we = 0; x_a_addr = 0; x_a_din = '0;
    x_b_en = 0; x_b_addr = 0; x_clr_start = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_a_dout", a_dout, '0);
    chk("rst_b_dout", b_dout, '0);
    chk1("rst_a_valid", a_valid, 1'b0);
    chk1("rst_b_valid", b_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_clr_done", clr_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_a_ready", a_ready, 1'b1);
    chk1("rst_x_err", x_err, 1'b0);
    chk1("rst_x_a_ready", x_a_ready, 1'b1);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic xcyc(input logic ae, input logic [3:0] we,
                      input logic [3:0] aa, input line_t ad,
                      input logic be, input logic [3:0] ba,
                      input logic cs);
    x_a_en = ae; x_a_we = we; x_a_addr = aa; x_a_din = ad;
    x_b_en = be; x_b_addr = ba; x_clr_start = cs;
    @(negedge clk);
  endtask

  task automatic xidle();
    xcyc(1'b0, 4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    line_t zero, d4321, lm, aa, bb;
    line_t obs [4];
    int    nb, nd;
    zero  = '0;
    d4321 = {32'h4, 32'h3, 32'h2, 32'h1};
    lm    = {32'h0, 32'h3, 32'h0, 32'h1};
    aa    = {4{32'hAAAA_AAAA}};
    bb    = {4{32'hBBBB_BBBB}};
    tbl[0] = '{1'b1, 4'hF, 4'd2, zero, 1'b0, 4'd0, 1'b0, zero, 1'b0, zero};
    tbl[1] = '{1'b1, 4'hF, 4'd5, zero, 1'b0, 4'd0, 1'b0, zero, 1'b0, zero};
    tbl[2] = '{1'b1, 4'b0101, 4'd2, d4321, 1'b0, 4'd0, 1'b1, zero, 1'b0, zero};
    tbl[3] = '{1'b1, 4'h0, 4'd2, zero, 1'b0, 4'd0, 1'b1, lm, 1'b0, zero};
    tbl[4] = '{1'b1, 4'hF, 4'd5, aa, 1'b1, 4'd5, 1'b1, zero, 1'b1, zero};
    tbl[5] = '{1'b0, 4'h0, 4'd0, zero, 1'b1, 4'd5, 1'b0, zero, 1'b1, aa};
    tbl[6] = '{1'b1, 4'h0, 4'd5, zero, 1'b1, 4'd2, 1'b1, aa, 1'b1, lm};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      a_en = 1; a_we = 4'hF; a_addr = 4'(i); a_din = '0;
      x_a_en = (i < 12); x_a_we = 4'hF; x_a_addr = 4'(i);
      x_a_din = pat(i + 20);
      mref[i] = '0;
      @(negedge clk);
    end
    do_reset();

    foreach (tbl[k]) begin
      cycle(tbl[k].ae, tbl[k].we, tbl[k].aa, tbl[k].ad,
            tbl[k].be, tbl[k].ba, 1'b0);
      repeat (LAT - 1) idle();
      if (tbl[k].ca) chk($sformatf("tbl%0d_a", k), a_dout, tbl[k].ea);
      if (tbl[k].cb) chk($sformatf("tbl%0d_b", k), b_dout, tbl[k].eb);
    end

    cycle(1'b1, 4'hF, 4'd5, bb, 1'b1, 4'd5, 1'b0);
    obs[1] = b_dout;
    cycle(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd5, 1'b0);
    obs[2] = b_dout;
    idle();
    obs[3] = b_dout;
    chk("coll_old", obs[LAT], aa);
    chk("coll_new", obs[LAT+1], bb);

    for (int i = 10; i < 16; i++)
      cycle(1'b1, 4'hF, 4'(i), pat(i), 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b1);
    nb = 0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      nb += int'(busy);
      nd += int'(clr_done);
      cycle(1'b1, 4'h0, 4'd3, '0, 1'b0, 4'h0, 1'b0);
    end
    chk("busy_cycles", line_t'(nb), line_t'(4));
    chk("done_pulses", line_t'(nd), line_t'(1));
    for (int i = 10; i < 16; i++)
      rd_check(i, (i >= 11 && i <= 14) ? '0 : pat(i),
               $sformatf("clr_line%0d", i));

    for (int i = 11; i < 15; i++)
      cycle(1'b1, 4'hF, 4'(i), pat(i), 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 4'hF, 4'd9, pat(9), 1'b0, 4'h0, 1'b1);
    idle();
    idle();
    do_reset();
    repeat (6) idle();
    chk1("abort_done", clr_done, 1'b0);
    rd_check(9, pat(9), "abort_line9");
    rd_check(11, '0, "abort_line11");
    rd_check(12, '0, "abort_line12");
    rd_check(13, pat(13), "abort_line13");
    rd_check(14, pat(14), "abort_line14");

    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 7, 4'($urandom),
            $urandom_range(0, 29) == 0);
    repeat (6) idle();

    chk1("oor_err_pre", x_err, 1'b0);
    xcyc(1'b1, 4'hF, 4'd14, aa, 1'b0, 4'h0, 1'b0);
    repeat (LAT - 1) xidle();
    chk1("oor_valid", x_a_valid, 1'b1);
    chk("oor_data", x_a_dout, '0);
    chk1("oor_err", x_err, 1'b1);
    for (int i = 0; i < 12; i++) begin
      xcyc(1'b1, 4'h0, 4'(i), '0, 1'b0, 4'h0, 1'b0);
      repeat (LAT - 1) xidle();
      chk($sformatf("oor_line%0d", i), x_a_dout, pat(i + 20));
    end
    chk1("err_sticky", x_err, 1'b1);
    xcyc(1'b0, 4'h0, 4'h0, '0, 1'b1, 4'd15, 1'b0);
    repeat (LAT - 1) xidle();
    chk1("oor_b_valid", x_b_valid, 1'b1);
    chk("oor_b_data", x_b_dout, '0);
    chk1("err_hold", x_err, 1'b1);
    xcyc(1'b0, 4'h0, 4'h0, '0, 1'b0, 4'h0, 1'b1);
    chk1("err_clr", x_err, 1'b0);
    chk1("x_busy", x_busy, 1'b1);
    repeat (6) xidle();
    chk1("x_idle_err", x_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
